// File: rtl/nx_alu_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | nx_alu_seq_if : request/result bundle for the sequential chunked adder  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface nx_alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CI;
  logic             BI;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] X;
  logic             CO;
  logic             V;
  logic             BUSY;

  modport master (
    output IN_VALID, A, B, CI, BI, OUT_READY,
    input  IN_READY, OUT_VALID, Y, X, CO, V, BUSY
  );

  modport slave (
    input  IN_VALID, A, B, CI, BI, OUT_READY,
    output IN_READY, OUT_VALID, Y, X, CO, V, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/nx_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | nx_alu_seq : WIDTH-bit add/sub evaluated one CHUNK-bit carry segment    |
// | per cycle, LSB first, with the inter-chunk carry held in a register.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module nx_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          CK,
  input  logic          RN,
  nx_alu_seq_if.slave   bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bb;
  logic             r_c;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_x;
  logic             r_co;
  logic             r_v;

  logic [CHUNK-1:0] w_a_ck;
  logic [CHUNK-1:0] w_b_ck;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    bus.IN_READY  = 1'b0;
    bus.OUT_VALID = 1'b0;
    bus.BUSY      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.IN_READY = 1'b1;
        if (bus.IN_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        bus.BUSY = 1'b1;
        if (r_k == C_K_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.OUT_VALID = 1'b1;
        bus.IN_READY  = bus.OUT_READY;
        // Result handshake and next accept may share one edge.
        if (bus.OUT_READY) begin
          if (bus.IN_VALID) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_last = (r_state == S_RUN) && (r_k == C_K_LAST);

  assign w_a_ck = r_a[int'(r_k) * CHUNK +: CHUNK];
  assign w_b_ck = r_bb[int'(r_k) * CHUNK +: CHUNK];
  assign {w_cout, w_s} = {1'b0, w_a_ck} + {1'b0, w_b_ck} + {{CHUNK{1'b0}}, r_c};
  // Carry into the chunk MSB, recovered from the sum bit.
  assign w_cmsb = w_s[CHUNK-1] ^ w_a_ck[CHUNK-1] ^ w_b_ck[CHUNK-1];

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_a  <= '0;
      r_bb <= '0;
      r_c  <= 1'b0;
      r_k  <= '0;
      r_y  <= '0;
      r_x  <= '0;
      r_co <= 1'b0;
      r_v  <= 1'b0;
    end else if (w_accept) begin
      r_a  <= bus.A;
      r_bb <= bus.BI ? ~bus.B : bus.B;
      r_c  <= bus.CI;
      r_k  <= '0;
    end else if (r_state == S_RUN) begin
      r_y[int'(r_k) * CHUNK +: CHUNK] <= w_s;
      r_x[int'(r_k) * CHUNK +: CHUNK] <= w_a_ck ^ w_b_ck;
      r_c <= w_cout;
      r_k <= r_k + KW'(1);
      if (w_last) begin
        r_co <= w_cout;
        r_v  <= w_cmsb ^ w_cout;
      end
    end
  end

  assign bus.Y  = r_y;
  assign bus.X  = r_x;
  assign bus.CO = r_co;
  assign bus.V  = r_v;
endmodule
`default_nettype wire

// File: tb/tb_nx_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_nx_alu_seq : scoreboard bench for nx_alu_seq (full-width model)      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_nx_alu_seq;
  localparam int W   = 32;
  localparam int CH  = 8;
  localparam int NCH = W / CH;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  nx_alu_seq_if #(.WIDTH(W), .CHUNK(CH)) bus ();

  nx_alu_seq #(.WIDTH(W), .CHUNK(CH)) dut (
    .CK  (clk),
    .RN  (rn),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] x;
    logic         co;
    logic         v;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: held low, 2: random

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic bi, input int acc);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb    = bi ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    e.y   = full[W-1:0];
    e.co  = full[W];
    e.x   = a ^ bb;
    e.v   = (a[W-1] == bb[W-1]) && (e.y[W-1] != a[W-1]);
    e.acc = acc;
    return e;
  endfunction

  task automatic check(input string name, input logic [2*W+1:0] act, input logic [2*W+1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: predicts control outputs from the scoreboard and checks results.
  always @(negedge clk) begin
    logic exp_busy, exp_ov, exp_ir;
    if (!rn) begin
      sb.delete();
      check("reset_ctrl", {63'd0, bus.BUSY, bus.OUT_VALID, bus.IN_READY}, 66'b001);
      check("reset_data", {bus.Y, bus.X, bus.CO, bus.V}, '0);
    end else begin
      exp_busy = (sb.size() > 0) && (cyc < sb[0].acc + NCH);
      exp_ov   = (sb.size() > 0) && (cyc >= sb[0].acc + NCH);
      exp_ir   = (sb.size() == 0) || (exp_ov && bus.OUT_READY);
      check("ctrl busy/valid/ready", {63'd0, bus.BUSY, bus.OUT_VALID, bus.IN_READY},
            {63'd0, exp_busy, exp_ov, exp_ir});
      if (exp_ov) begin
        check("result y/x/co/v", {bus.Y, bus.X, bus.CO, bus.V},
              {sb[0].y, sb[0].x, sb[0].co, sb[0].v});
        if (bus.OUT_READY) void'(sb.pop_front());
      end
      if (bus.IN_VALID && exp_ir)
        sb.push_back(model(bus.A, bus.B, bus.CI, bus.BI, cyc + 1));
    end
  end

  initial begin
    bus.OUT_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.OUT_READY = 1'b1;
        1:       bus.OUT_READY = 1'b0;
        default: bus.OUT_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic bi);
    bus.IN_VALID = 1'b1;
    bus.A  = a;
    bus.B  = b;
    bus.CI = ci;
    bus.BI = bi;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.IN_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got IN_READY=0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    bus.A  = $urandom;
    bus.B  = $urandom;
    bus.CI = 1'($urandom_range(0, 1));
    bus.BI = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic bi);
    drive_req(a, b, ci, bi);
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit seen;
    bus.IN_VALID = 1'b0;
    bus.A  = '0;
    bus.B  = '0;
    bus.CI = 1'b0;
    bus.BI = 1'b0;
    repeat (3) @(posedge clk);
    #1 rn = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, issued back-to-back against an always-ready consumer.
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
    issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    drain();

    // Backpressure with a competing request held in DONE.
    #2 rdy_mode = 1;
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.OUT_VALID) begin
        seen = 1'b1;
        break;
      end
    end
    check("valid_after_backpressure_issue", {65'd0, seen}, 66'd1);
    @(posedge clk);
    #1 drive_req(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #2 rdy_mode = 0;
    wait_accept();
    drain();

    // Asynchronous reset in the middle of an operation (chunk k=2).
    issue(32'hCAFE_0123, 32'h4567_89AB, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rn = 1'b0;
    #1;
    check("async_reset_ctrl", {63'd0, bus.BUSY, bus.OUT_VALID, bus.IN_READY}, 66'b001);
    check("async_reset_data", {bus.Y, bus.X, bus.CO, bus.V}, '0);
    repeat (2) @(posedge clk);
    #1 rn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    drain();

    // Random operands, gaps and consumer backpressure.
    #2 rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    #2 rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nx_alu_seq.md
# nx_alu_seq

Sequential wide adder/subtractor controller for the NanoXplore carry-chain datapath. It runs one WIDTH-bit `$alu`-style operation (Y = A + (BI ? ~B : B) + CI) on a single CHUNK-bit NX_CY carry segment, one chunk per cycle from LSB to MSB. Between cycles it holds the chunk carry in a register. It sits between a requester using a valid/ready handshake and a consumer, and trades latency for carry-chain area on wide arithmetic.

## Interface

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits per cycle; must be a multiple of 4 (one NX_CY per 4 bits), 4 ≤ CHUNK ≤ WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam; number of RUN cycles.

Ports:
- CK  in  1  clock; all state changes on rising edge.
- RN  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  controller can accept a request.
- A  in  WIDTH  operand A, unsigned bit vector.
- B  in  WIDTH  operand B.
- CI  in  1  carry in.
- BI  in  1  invert B (subtract when CI=1).
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- Y  out  WIDTH  sum.
- X  out  WIDTH  A ^ (BI ? ~B : B).
- CO  out  1  carry out of bit WIDTH-1.
- V  out  1  signed overflow: carry into bit WIDTH-1 XOR CO.
- BUSY  out  1  high in RUN.

## Operation

- States: IDLE, RUN, DONE. Chunk counter k counts 0..NCHUNK-1.
- IDLE: IN_READY=1. When IN_VALID is high the request is accepted:
  - latch A and BB = BI ? ~B : B;
  - carry register c ← CI, k ← 0;
  - go to RUN.
- RUN: each cycle computes {cout, s} = A[k] + BB[k] + c on chunk k (CHUNK bits, LSB chunk first).
  - Y chunk k ← s; X chunk k ← A[k]^BB[k]; c ← cout; k ← k+1.
  - On k = NCHUNK-1: CO ← cout, V ← (carry into bit CHUNK-1 of the chunk) XOR cout, then go to DONE.
- DONE: OUT_VALID=1. Y, X, CO and V are held stable until OUT_VALID && OUT_READY.
  - On the handshake, if IN_VALID is also high, the new request is accepted in the same cycle and the state goes to RUN. Otherwise go to IDLE.
- IN_READY = (state==IDLE) || (state==DONE && OUT_READY). It is combinational from state and OUT_READY only, not from IN_VALID.
- Requests are ignored and never queued while IN_READY=0.
- A, B, CI and BI are sampled only on the accept edge. Changing them afterwards does not affect the operation in flight.
- Y and X are only defined while OUT_VALID=1. In RUN they hold partially updated values.
- Wrap-around: arithmetic is modulo 2^WIDTH. CO reports the carry; with BI=1, CI=1, CO=1 means A ≥ B unsigned.
- Reset (RN low, at any time including mid-RUN or DONE):
  - state=IDLE, k=0, c=0;
  - Y, X, CO, V, OUT_VALID, BUSY = 0; IN_READY=1.
  - An aborted operation never produces OUT_VALID.

## Timing

- Accept edge T: the rising edge with IN_VALID && IN_READY.
- BUSY=1 from T through T+NCHUNK-1; OUT_VALID=1 from T+NCHUNK.
- Latency from accept to OUT_VALID is NCHUNK cycles (4 with defaults).
- Max throughput is one operation per NCHUNK+1 cycles, achieved with back-to-back handshakes in DONE.
- Critical path is one CHUNK-bit carry segment plus the carry register mux; there is no WIDTH-length combinational chain.
- RN assertion acts immediately. Release is synchronous in effect: first accept is possible on the first edge after RN=1.

## Test plan

- Add ripple, WIDTH=32, CHUNK=8: A=0x0000_00FF, B=1, CI=0, BI=0 → 4 cycles after accept OUT_VALID=1, Y=0x0000_0100, CO=0, V=0, X=0x0000_00FE.
- Full-carry propagation: A=0xFFFF_FFFF, B=0, CI=1 → Y=0, CO=1, V=0. Then A=0x7FFF_FFFF, B=1, CI=0 → Y=0x8000_0000, CO=0, V=1.
- Subtract:
  - A=7, B=5, BI=1, CI=1 → Y=2, CO=1, V=0.
  - A=5, B=7 → Y=0xFFFF_FFFE, CO=0.
  - A=0x8000_0000, B=1 → Y=0x7FFF_FFFF, V=1.
- Backpressure: OUT_READY=0 for 5 cycles in DONE while IN_VALID=1 with new operands → OUT_VALID stays 1, Y/CO/V unchanged, IN_READY=0, no new operation starts. Raising OUT_READY completes the handshake.
- Back-to-back: OUT_READY=1 and IN_VALID=1 in DONE → second request accepted on the same edge as the result handshake, OUT_VALID=0 next cycle, second result 4 cycles later. Operands changed after accept do not alter either result.
- Reset mid-RUN: assert RN during cycle k=2 → immediately all outputs 0, IN_READY=1. After release, OUT_VALID stays 0 with no request. A new request A=1, B=1 → Y=2 after 4 cycles.
